// File: rtl/softmax_sum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softmax_sum_ctrl_pkg
// Description : Shared fixed-point constants, default sizing and FSM state
//               encoding for the softmax denominator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package softmax_sum_ctrl_pkg;

  // Fixed-point format of exp values, tree sums and the row accumulator.
  localparam int FP_DATA_WIDTH = 16;
  localparam int FP_FRAC_BITS  = 8;
  localparam int FP_INT_BITS   = FP_DATA_WIDTH - FP_FRAC_BITS;

  // 1.0 in the default fixed-point format.
  localparam logic [FP_DATA_WIDTH-1:0] ONE_FIXED =
    FP_DATA_WIDTH'(1) << FP_FRAC_BITS;

  // Default row geometry and add-tree latency.
  localparam int SM_NUM_INPUTS = 4;
  localparam int SM_MAX_BEATS  = 16;
  localparam int SM_TREE_LAT   = 2;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUT    = 2'd3
  } sm_state_t;

endpackage : softmax_sum_ctrl_pkg
`default_nettype wire

// File: rtl/softmax_sum_ctrl_sum_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sum_tag_pipe
// Description : DEPTH-deep 1-bit shift register that tracks which cycles of
//               the external add tree carry a real beat. A 1 pushed in the
//               cycle tree_data is driven emerges on tag_out exactly DEPTH
//               cycles later, aligned with the matching tree_sum.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low clear
//   push     in   1 = a beat enters the add tree this cycle
//   tag_out  out  1 = tree_sum is valid this cycle
// ============================================================================
module sum_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic tag_out
);

  logic [DEPTH-1:0] tags;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) tags <= '0;
        else      tags <= push;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) tags <= '0;
        else      tags <= {tags[DEPTH-2:0], push};
      end
    end
  endgenerate

  assign tag_out = tags[DEPTH-1];

endmodule : sum_tag_pipe
`default_nettype wire

// File: rtl/softmax_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : softmax_sum_ctrl
// Description : Softmax denominator sequencer. Streams one row of exp values
//               (NUM_INPUTS lanes per beat) into an external pipelined add
//               tree, accumulates the returned per-beat sums with unsigned
//               saturation, clamps the row total to >= 1.0 and hands it to
//               the divider through a valid/ready handshake.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle row start pulse (honoured only in IDLE)
//   row_beats  in   beats in the row, sampled with an accepted start
//   busy       out  controller is not idle
//   in_valid   in   upstream beat valid
//   in_ready   out  controller accepts a beat
//   in_data    in   NUM_INPUTS packed exp values of one beat
//   tree_data  out  to the add tree; in_data on accept, otherwise zero
//   tree_sum   in   add tree result, TREE_LAT cycles after tree_data
//   sum_valid  out  row sum available
//   sum_ready  in   downstream accepts the sum
//   sum_out    out  clamped row sum
//   sat_flag   out  accumulator saturated during this row (sticky)
// ============================================================================
module softmax_sum_ctrl
  import softmax_sum_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS = SM_NUM_INPUTS,
  parameter int DATA_WIDTH = FP_DATA_WIDTH,
  parameter int FRAC_BITS  = FP_FRAC_BITS,
  parameter int MAX_BEATS  = SM_MAX_BEATS,
  parameter int TREE_LAT   = SM_TREE_LAT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_BEATS+1)-1:0]   row_beats,
  output logic                             busy,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] tree_data,
  input  logic [DATA_WIDTH-1:0]            tree_sum,
  output logic                             sum_valid,
  input  logic                             sum_ready,
  output logic [DATA_WIDTH-1:0]            sum_out,
  output logic                             sat_flag
);

  localparam int                    CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [DATA_WIDTH-1:0] ONE_VAL = DATA_WIDTH'(1) << FRAC_BITS;

  sm_state_t             state;
  sm_state_t             state_nxt;
  logic [CNT_W-1:0]      beats_q;     // latched (clamped) row length
  logic [CNT_W-1:0]      issued;      // beats sent into the tree
  logic [CNT_W-1:0]      done;        // tree results accumulated
  logic [CNT_W-1:0]      done_nxt;
  logic [CNT_W-1:0]      beats_clamped;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [DATA_WIDTH:0]   acc_wide;
  logic                  add_ovf;
  logic                  accept;
  logic                  start_go;
  logic                  tag_out;

  // Values below 1.0 would blow up the divider, so they become exactly 1.0.
  function automatic logic [DATA_WIDTH-1:0] clamp_one(input logic [DATA_WIDTH-1:0] v);
    return (v[DATA_WIDTH-1:FRAC_BITS] == '0) ? ONE_VAL : v;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and status outputs
  // --------------------------------------------------------------------------
  assign busy          = (state != ST_IDLE);
  assign sum_valid     = (state == ST_OUT);
  assign in_ready      = (state == ST_STREAM) && (issued < beats_q);
  assign accept        = in_valid & in_ready;
  assign tree_data     = accept ? in_data : '0;
  assign start_go      = (state == ST_IDLE) && start;
  assign beats_clamped = (row_beats > MAX_CNT) ? MAX_CNT : row_beats;

  // --------------------------------------------------------------------------
  // Valid-tag pipe alongside the add tree; cleared by reset so that results
  // still inside the tree at reset time are never accumulated.
  // --------------------------------------------------------------------------
  sum_tag_pipe #(
    .DEPTH (TREE_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .tag_out (tag_out)
  );

  // --------------------------------------------------------------------------
  // Saturating accumulate of the tree result that is valid this cycle
  // --------------------------------------------------------------------------
  always_comb begin
    acc_wide = {1'b0, acc} + {1'b0, tree_sum};
    add_ovf  = tag_out & acc_wide[DATA_WIDTH];
    acc_nxt  = acc;
    done_nxt = done;
    if (tag_out) begin
      acc_nxt  = acc_wide[DATA_WIDTH] ? '1 : acc_wide[DATA_WIDTH-1:0];
      done_nxt = done + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (row_beats == '0) ? ST_OUT : ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && ((issued + 1'b1) == beats_q)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Looks at the post-add count so the final tree result is included.
        if (done_nxt == beats_q) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (sum_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q  <= '0;
      issued   <= '0;
      done     <= '0;
      acc      <= '0;
      sat_flag <= 1'b0;
      sum_out  <= '0;
    end else begin
      acc  <= acc_nxt;
      done <= done_nxt;
      if (add_ovf) sat_flag <= 1'b1;
      if (accept)  issued   <= issued + 1'b1;

      if (start_go) begin
        beats_q  <= beats_clamped;
        issued   <= '0;
        done     <= '0;
        acc      <= '0;
        sat_flag <= 1'b0;
        // An empty row has a zero total, which clamps to 1.0.
        if (row_beats == '0) sum_out <= ONE_VAL;
      end

      if ((state == ST_DRAIN) && (state_nxt == ST_OUT)) begin
        sum_out <= clamp_one(acc_nxt);
      end
    end
  end

endmodule : softmax_sum_ctrl
`default_nettype wire
